// File: rtl/motion_step_scheduler_pkg.sv
// Shared types for the motion path: direction codes (also used by the
// direction FSM) and the step scheduler state encoding.
package motion_step_scheduler_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_FINISH
  } state_e;

  localparam int STEPS_W_DEF    = 8;
  localparam int CNT_W_DEF      = 16;
  localparam int SETTLE_CYC_DEF = 4;

endpackage

// File: rtl/motion_step_scheduler_if.sv
// Command handshake between the direction FSM (master) and the step scheduler (slave).
interface motion_step_scheduler_if #(
  parameter int STEPS_W = 8,
  parameter int CNT_W   = 16
);
  import motion_step_scheduler_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  dir_e               cmd_dir;
  logic [STEPS_W-1:0] cmd_steps;
  logic [CNT_W-1:0]   cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/motion_step_scheduler_step_timer.sv
// Loadable down-counter; expire is high for the cycle the count reaches 1,
// and the counter reloads the last loaded value on that same edge.
module motion_step_scheduler_step_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload;

  assign expire = en && !load && (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      reload <= '0;
    end else if (load) begin
      cnt    <= value;
      reload <= value;
    end else if (en) begin
      cnt <= expire ? reload : cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/motion_step_scheduler.sv
// Turns one accepted move command into settle time plus timed step pulses,
// aborting on the obstacle sensor of the commanded direction.
module motion_step_scheduler
  import motion_step_scheduler_pkg::*;
#(
  parameter int STEPS_W    = 8,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  motion_step_scheduler_if.slave   cmd,
  input  logic [3:0]               sensor,
  output dir_e                     motor_dir,
  output logic                     step_pulse,
  output logic                     busy,
  output logic                     done,
  output logic                     blocked,
  output logic [STEPS_W-1:0]       steps_done
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  state_e             state, state_n;
  logic [STEPS_W-1:0] steps_q;
  logic [CNT_W-1:0]   period_q;
  logic [SW-1:0]      settle_cnt;

  logic               accept, active, abort, pulse_n;
  logic               tmr_load, tmr_en, tmr_expire;
  logic [CNT_W-1:0]   period_fix, tmr_value;

  assign period_fix = (cmd.cmd_period == '0) ? CNT_W'(1) : cmd.cmd_period;
  assign accept     = (state == ST_IDLE) && cmd.cmd_valid && cmd.cmd_ready;
  assign active     = (state == ST_SETTLE) || (state == ST_RUN);
  assign abort      = active && sensor[motor_dir];

  // The timer runs during the last settle cycle so that, with the pulse
  // registered, the first strobe lands exactly period cycles into RUN.
  assign tmr_load  = (SETTLE_CYC == 1) ? (accept && (cmd.cmd_steps != '0))
                                       : ((state == ST_SETTLE) && (settle_cnt == SW'(1)));
  assign tmr_value = (state == ST_IDLE) ? period_fix : period_q;
  assign tmr_en    = ((state == ST_SETTLE) && (settle_cnt == '0)) || (state == ST_RUN);

  // steps_done already includes a pulse showing this cycle.
  assign pulse_n = tmr_expire && !abort && (steps_done < steps_q);

  motion_step_scheduler_step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (accept) state_n = (cmd.cmd_steps == '0) ? ST_FINISH : ST_SETTLE;
      ST_SETTLE: begin
        if (abort)                  state_n = ST_IDLE;
        else if (settle_cnt == '0)  state_n = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                                     state_n = ST_IDLE;
        else if (step_pulse && (steps_done == steps_q)) state_n = ST_FINISH;
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd.cmd_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      blocked       <= 1'b0;
      step_pulse    <= 1'b0;
      motor_dir     <= DIR_UP;
      steps_q       <= '0;
      period_q      <= '0;
      steps_done    <= '0;
      settle_cnt    <= '0;
    end else begin
      cmd.cmd_ready <= (state_n == ST_IDLE);
      busy          <= (state_n == ST_SETTLE) || (state_n == ST_RUN);
      done          <= (state_n == ST_FINISH);
      blocked       <= abort;
      step_pulse    <= pulse_n;
      if (accept) begin
        motor_dir  <= cmd.cmd_dir;
        steps_q    <= cmd.cmd_steps;
        period_q   <= period_fix;
        steps_done <= '0;
        settle_cnt <= SW'(SETTLE_CYC - 1);
      end else begin
        if ((state == ST_SETTLE) && (settle_cnt != '0)) settle_cnt <= settle_cnt - SW'(1);
        if (pulse_n) steps_done <= steps_done + STEPS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_motion_step_scheduler.sv
// Directed bench for the step scheduler: per-move cycle traces compared against hand-built masks.
module tb_motion_step_scheduler;
  import motion_step_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sensor = 4'b0;
  dir_e       motor_dir;
  logic       step_pulse, busy, done, blocked;
  logic [7:0] steps_done;

  motion_step_scheduler_if #(.STEPS_W(8), .CNT_W(16)) cmd ();

  motion_step_scheduler #(.STEPS_W(8), .CNT_W(16), .SETTLE_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .sensor     (sensor),
    .motor_dir  (motor_dir),
    .step_pulse (step_pulse),
    .busy       (busy),
    .done       (done),
    .blocked    (blocked),
    .steps_done (steps_done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] pm, dm, bm, bym, rm;
  logic [7:0]  sd_at [64];
  dir_e        dir_at [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rng(input int a, input int b);
    logic [63:0] r;
    r = '0;
    for (int i = a; i <= b; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] b1(input int k);
    logic [63:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // Offers a command at a negedge where cmd_ready is seen; returns in cycle A+1.
  task automatic issue(input dir_e d, input int st, input int per);
    int w;
    w = 0;
    while (!cmd.cmd_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) chk("ready_timeout", 64'(cmd.cmd_ready), 64'd1);
    cmd.cmd_dir    = d;
    cmd.cmd_steps  = 8'(st);
    cmd.cmd_period = 16'(per);
    cmd.cmd_valid  = 1'b1;
    tick();
  endtask

  // Records cycles A+1..A+n; sensor=sv during A+s0..A+s1; cmd_valid dropped in A+drop_k.
  task automatic run(input int n, input int s0, input int s1, input logic [3:0] sv, input int drop_k);
    pm = '0; dm = '0; bm = '0; bym = '0; rm = '0;
    for (int k = 1; k <= n; k++) begin
      if (k == drop_k) cmd.cmd_valid = 1'b0;
      sensor    = (k >= s0 && k <= s1) ? sv : 4'b0;
      pm[k]     = step_pulse;
      dm[k]     = done;
      bm[k]     = blocked;
      bym[k]    = busy;
      rm[k]     = cmd.cmd_ready;
      sd_at[k]  = steps_done;
      dir_at[k] = motor_dir;
      tick();
    end
    sensor = 4'b0;
  endtask

  initial begin
    cmd.cmd_valid  = 1'b0;
    cmd.cmd_dir    = DIR_UP;
    cmd.cmd_steps  = '0;
    cmd.cmd_period = '0;

    // reset state
    #2 rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 64'(cmd.cmd_ready), 64'd0);
    chk("rst_busy",  64'(busy),          64'd0);
    chk("rst_pulse", 64'(step_pulse),    64'd0);
    chk("rst_done",  64'(done),          64'd0);
    chk("rst_blk",   64'(blocked),       64'd0);
    chk("rst_sd",    64'(steps_done),    64'd0);
    chk("rst_dir",   64'(motor_dir),     64'(DIR_UP));
    rst = 1'b0;
    #1 chk("rel_ready_pre", 64'(cmd.cmd_ready), 64'd0);
    tick();
    chk("rel_ready", 64'(cmd.cmd_ready), 64'd1);

    // 1: RIGHT, 3 steps, period 5
    issue(DIR_RIGHT, 3, 5);
    run(22, 0, -1, 4'b0, 1);
    chk("t1_pulse", pm,  b1(9) | b1(14) | b1(19));
    chk("t1_done",  dm,  b1(20));
    chk("t1_blk",   bm,  64'd0);
    chk("t1_busy",  bym, rng(1, 19));
    chk("t1_ready", rm,  rng(21, 22));
    chk("t1_sd",    64'(sd_at[21]), 64'd3);
    chk("t1_dir",   64'(dir_at[1]), 64'(DIR_RIGHT));

    // 2: zero steps
    issue(DIR_UP, 0, 7);
    run(4, 0, -1, 4'b0, 1);
    chk("t2_pulse", pm,  64'd0);
    chk("t2_done",  dm,  b1(1));
    chk("t2_busy",  bym, 64'd0);
    chk("t2_ready", rm,  rng(2, 4));

    // 3: own-direction sensor aborts after the first pulse
    issue(DIR_RIGHT, 4, 5);
    run(20, 10, 10, 4'b0010, 1);
    chk("t3_pulse", pm,  b1(9));
    chk("t3_blk",   bm,  b1(11));
    chk("t3_done",  dm,  64'd0);
    chk("t3_busy",  bym, rng(1, 10));
    chk("t3_ready", rm,  rng(11, 20));
    chk("t3_sd",    64'(sd_at[11]), 64'd1);
    chk("t3_sd_end", 64'(sd_at[20]), 64'd1);

    // 4: other-direction sensor ignored
    issue(DIR_RIGHT, 4, 5);
    run(27, 1, 27, 4'b1000, 1);
    chk("t4_pulse", pm, b1(9) | b1(14) | b1(19) | b1(24));
    chk("t4_done",  dm, b1(25));
    chk("t4_blk",   bm, 64'd0);
    chk("t4_sd",    64'(sd_at[26]), 64'd4);

    // 5: period 0 behaves as 1
    issue(DIR_UP, 3, 0);
    run(10, 0, -1, 4'b0, 1);
    chk("t5_pulse", pm, rng(5, 7));
    chk("t5_done",  dm, b1(8));
    chk("t5_sd",    64'(sd_at[9]), 64'd3);

    // 6: reset mid-RUN
    issue(DIR_RIGHT, 3, 5);
    run(9, 0, -1, 4'b0, 1);
    chk("t6_pulse_pre", pm, b1(9));
    #2 rst = 1'b1;
    #1;
    chk("t6_busy",  64'(busy),          64'd0);
    chk("t6_sd",    64'(steps_done),    64'd0);
    chk("t6_dir",   64'(motor_dir),     64'(DIR_UP));
    chk("t6_ready", 64'(cmd.cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t6_ready_rel", 64'(cmd.cmd_ready), 64'd1);
    issue(DIR_DOWN, 1, 1);
    run(8, 0, -1, 4'b0, 1);
    chk("t6_pulse", pm, b1(5));
    chk("t6_done",  dm, b1(6));
    chk("t6_dir2",  64'(dir_at[1]), 64'(DIR_DOWN));

    // 7: cmd_valid held through a move; second command waits for cmd_ready
    issue(DIR_RIGHT, 1, 2);
    cmd.cmd_dir    = DIR_LEFT;
    cmd.cmd_steps  = 8'd2;
    cmd.cmd_period = 16'd1;
    run(17, 0, -1, 4'b0, 9);
    chk("t7_pulse", pm,  b1(6) | b1(13) | b1(14));
    chk("t7_done",  dm,  b1(7) | b1(15));
    chk("t7_ready", rm,  b1(8) | rng(16, 17));
    chk("t7_busy",  bym, rng(1, 6) | rng(9, 14));
    chk("t7_dir8",  64'(dir_at[8]), 64'(DIR_RIGHT));
    chk("t7_dir9",  64'(dir_at[9]), 64'(DIR_LEFT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
